hazard_controller: RTL and testbench



---
 rtl/hazard_pkg.sv | 39 +++
 rtl/hazard_controller_if.sv | 40 ++++
 rtl/md_sequencer.sv | 63 ++++++
 rtl/hazard_controller.sv | 50 +++++
 tb/tb_hazard_controller.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared forwarding selects, sequencer states and hazard helpers
package hazard_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } md_state_t;

    // The memory stage holds the younger result, so it wins over writeback.
    function automatic logic [1:0] fwdSel(
        input logic       regWriteM,
        input logic [4:0] writeRegM,
        input logic       regWriteW,
        input logic [4:0] writeRegW,
        input logic [4:0] src
    );
        if (regWriteM && writeRegM != 5'd0 && writeRegM == src) begin
            return FWD_MEM;
        end
        if (regWriteW && writeRegW != 5'd0 && writeRegW == src) begin
            return FWD_WB;
        end
        return FWD_RF;
    endfunction

    function automatic logic regHit(
        input logic [4:0] dst,
        input logic [4:0] srcA,
        input logic [4:0] srcB
    );
        return (dst != 5'd0) && (dst == srcA || dst == srcB);
    endfunction

endpackage

// File: rtl/hazard_controller_if.sv
// rtl/hazard_controller_if.sv - pipeline register taps and hazard control outputs
interface hazard_controller_if;

    logic [4:0] RsD;
    logic [4:0] RtD;
    logic       BranchD;
    logic [4:0] RsE;
    logic [4:0] RtE;
    logic [4:0] WriteRegE;
    logic       RegWriteE;
    logic       MemToRegE;
    logic       MdStartE;
    logic [4:0] WriteRegM;
    logic       RegWriteM;
    logic       MemToRegM;
    logic [4:0] WriteRegW;
    logic       RegWriteW;

    logic [1:0] ForwardAE;
    logic [1:0] ForwardBE;
    logic       StallF;
    logic       StallD;
    logic       StallE;
    logic       FlushE;
    logic       MdBusy;
    logic       MdDone;

    modport master (
        output RsD, RtD, BranchD, RsE, RtE, WriteRegE, RegWriteE, MemToRegE, MdStartE,
               WriteRegM, RegWriteM, MemToRegM, WriteRegW, RegWriteW,
        input  ForwardAE, ForwardBE, StallF, StallD, StallE, FlushE, MdBusy, MdDone
    );

    modport slave (
        input  RsD, RtD, BranchD, RsE, RtE, WriteRegE, RegWriteE, MemToRegE, MdStartE,
               WriteRegM, RegWriteM, MemToRegM, WriteRegW, RegWriteW,
        output ForwardAE, ForwardBE, StallF, StallD, StallE, FlushE, MdBusy, MdDone
    );

endinterface

// File: rtl/md_sequencer.sv
// rtl/md_sequencer.sv - holds execute for a fixed number of cycles per mult/div
module md_sequencer
    import hazard_pkg::*;
#(
    parameter int MD_LATENCY = 32,
    parameter int CNT_W      = $clog2(MD_LATENCY)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic MdStartE,
    output logic mdhold,
    output logic MdBusy,
    output logic MdDone
);

    md_state_t        state;
    md_state_t        stateNext;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cntNext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
        end
    end

    // DONE ignores MdStartE: the start flag still belongs to the finishing instruction.
    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        mdhold    = 1'b0;
        case (state)
            IDLE: begin
                mdhold = MdStartE;
                if (MdStartE) begin
                    stateNext = BUSY;
                    cntNext   = CNT_W'(MD_LATENCY - 2);
                end
            end
            BUSY: begin
                mdhold  = 1'b1;
                cntNext = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    stateNext = DONE;
                end
            end
            DONE: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    assign MdBusy = (state == BUSY);
    assign MdDone = (state == DONE);

endmodule

// File: rtl/hazard_controller.sv
// rtl/hazard_controller.sv - execute forwarding selects, load-use/branch stalls and mult/div hold
module hazard_controller
    import hazard_pkg::*;
#(
    parameter int MD_LATENCY = 32,
    parameter int CNT_W      = $clog2(MD_LATENCY)
) (
    input  logic                clk,
    input  logic                rst_n,
    hazard_controller_if.slave  hz
);

    logic mdhold;
    logic lwstall;
    logic brstall;
    logic hazStall;

    md_sequencer #(
        .MD_LATENCY (MD_LATENCY),
        .CNT_W      (CNT_W)
    ) u_md_sequencer (
        .clk      (clk),
        .rst_n    (rst_n),
        .MdStartE (hz.MdStartE),
        .mdhold   (mdhold),
        .MdBusy   (hz.MdBusy),
        .MdDone   (hz.MdDone)
    );

    assign lwstall = hz.MemToRegE && hz.RegWriteE && regHit(hz.WriteRegE, hz.RsD, hz.RtD);

    assign brstall = hz.BranchD &&
                     ((hz.RegWriteE && regHit(hz.WriteRegE, hz.RsD, hz.RtD)) ||
                      (hz.MemToRegM && regHit(hz.WriteRegM, hz.RsD, hz.RtD)));

    assign hazStall = lwstall || brstall;

    // Combinational outputs are gated so the whole block reads as zero while in reset.
    assign hz.ForwardAE = rst_n ? fwdSel(hz.RegWriteM, hz.WriteRegM, hz.RegWriteW, hz.WriteRegW, hz.RsE)
                                : FWD_RF;
    assign hz.ForwardBE = rst_n ? fwdSel(hz.RegWriteM, hz.WriteRegM, hz.RegWriteW, hz.WriteRegW, hz.RtE)
                                : FWD_RF;

    assign hz.StallF = rst_n && (hazStall || mdhold);
    assign hz.StallD = rst_n && (hazStall || mdhold);
    assign hz.StallE = rst_n && mdhold;
    // A held mult/div must never be bubbled out of execute.
    assign hz.FlushE = rst_n && hazStall && !mdhold;

endmodule

// File: tb/tb_hazard_controller.sv
// tb/tb_hazard_controller.sv - directed vectors checked against a cycle-position model of the hazard controller
module tb_hazard_controller;

    localparam int L = 4;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   mdPos;

    hazard_controller_if hz();

    hazard_controller #(
        .MD_LATENCY (L),
        .CNT_W      ($clog2(L))
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] fwdModel(input logic [4:0] src);
        if (hz.RegWriteM && hz.WriteRegM != 0 && hz.WriteRegM == src) return 2'b10;
        if (hz.RegWriteW && hz.WriteRegW != 0 && hz.WriteRegW == src) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic hitD(input logic [4:0] dst);
        return dst != 0 && (dst == hz.RsD || dst == hz.RtD);
    endfunction

    // Position of the current cycle within a mult/div occupancy window (0..L-1), -1 when none.
    function automatic int curPos();
        if (mdPos >= 0) return mdPos;
        return hz.MdStartE ? 0 : -1;
    endfunction

    function automatic int nextPos();
        int p;
        p = curPos();
        return (p >= 0 && p < L - 1) ? p + 1 : -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) mdPos <= -1;
        else        mdPos <= nextPos();
    end

    always @(negedge clk) begin
        logic haz;
        logic hold;
        int   p;
        if (!rst_n) begin
            chk("rst_fwdA", hz.ForwardAE, 0);
            chk("rst_fwdB", hz.ForwardBE, 0);
            chk("rst_stall", {hz.StallF, hz.StallD, hz.StallE, hz.FlushE}, 0);
            chk("rst_md", {hz.MdBusy, hz.MdDone}, 0);
        end else begin
            haz  = (hz.MemToRegE && hz.RegWriteE && hitD(hz.WriteRegE)) ||
                   (hz.BranchD && ((hz.RegWriteE && hitD(hz.WriteRegE)) ||
                                   (hz.MemToRegM && hitD(hz.WriteRegM))));
            p    = curPos();
            hold = p >= 0 && p <= L - 2;
            chk("m_fwdA", hz.ForwardAE, fwdModel(hz.RsE));
            chk("m_fwdB", hz.ForwardBE, fwdModel(hz.RtE));
            chk("m_stallF", hz.StallF, haz || hold);
            chk("m_stallD", hz.StallD, haz || hold);
            chk("m_stallE", hz.StallE, hold);
            chk("m_flushE", hz.FlushE, haz && !hold);
            chk("m_busy", hz.MdBusy, mdPos >= 1 && mdPos <= L - 2);
            chk("m_done", hz.MdDone, mdPos == L - 1);
        end
    end

    task automatic clearIn();
        hz.RsD = 0; hz.RtD = 0; hz.BranchD = 0;
        hz.RsE = 0; hz.RtE = 0; hz.WriteRegE = 0; hz.RegWriteE = 0; hz.MemToRegE = 0; hz.MdStartE = 0;
        hz.WriteRegM = 0; hz.RegWriteM = 0; hz.MemToRegM = 0;
        hz.WriteRegW = 0; hz.RegWriteW = 0;
    endtask

    task automatic nextCyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] sv;
        logic [7:0] bv;
        logic [7:0] dv;
        total = 0;
        bad   = 0;
        clearIn();
        rst_n = 1'b0;
        hz.RsE = 5; hz.WriteRegM = 5; hz.RegWriteM = 1; hz.MdStartE = 1;
        hz.MemToRegE = 1; hz.RegWriteE = 1; hz.WriteRegE = 8; hz.RtD = 8;
        @(negedge clk);
        chk("lit_rst_fwdA", hz.ForwardAE, 2'b00);
        chk("lit_rst_stall", {hz.StallF, hz.StallD, hz.StallE, hz.FlushE}, 4'b0000);
        nextCyc();
        clearIn();
        rst_n = 1'b1;
        nextCyc();

        hz.RsE = 5; hz.WriteRegM = 5; hz.RegWriteM = 1; hz.WriteRegW = 5; hz.RegWriteW = 1;
        @(negedge clk); chk("lit_fwd_mem", hz.ForwardAE, 2'b10);
        nextCyc();
        hz.RegWriteM = 0; hz.RtE = 5;
        @(negedge clk); chk("lit_fwd_wb", hz.ForwardAE, 2'b01); chk("lit_fwdB_wb", hz.ForwardBE, 2'b01);
        nextCyc();
        hz.RsE = 0; hz.WriteRegW = 0;
        @(negedge clk); chk("lit_fwd_rf", hz.ForwardAE, 2'b00); chk("lit_fwdB_r0", hz.ForwardBE, 2'b00);
        nextCyc();
        clearIn();

        hz.MemToRegE = 1; hz.RegWriteE = 1; hz.WriteRegE = 8; hz.RtD = 8;
        @(negedge clk); chk("lit_lwuse", {hz.StallF, hz.StallD, hz.StallE, hz.FlushE}, 4'b1101);
        nextCyc();
        hz.WriteRegE = 0;
        @(negedge clk); chk("lit_lw_r0", {hz.StallF, hz.StallD, hz.StallE, hz.FlushE}, 4'b0000);
        nextCyc();
        clearIn();

        hz.BranchD = 1; hz.RsD = 3; hz.MemToRegM = 1; hz.WriteRegM = 3;
        @(negedge clk); chk("lit_br_mem", {hz.StallD, hz.FlushE}, 2'b11);
        nextCyc();
        clearIn();
        hz.BranchD = 1; hz.RtD = 4; hz.RegWriteE = 1; hz.WriteRegE = 4;
        @(negedge clk); chk("lit_br_ex", {hz.StallF, hz.StallD, hz.FlushE}, 3'b111);
        nextCyc();
        hz.BranchD = 0;
        @(negedge clk); chk("lit_nobr", {hz.StallF, hz.FlushE}, 2'b00);
        nextCyc();
        clearIn();
        nextCyc();

        sv = 0; bv = 0; dv = 0;
        hz.MdStartE = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            sv[i] = hz.StallE; bv[i] = hz.MdBusy; dv[i] = hz.MdDone;
            nextCyc();
        end
        hz.MdStartE = 0;
        chk("lit_md1_stallE", sv, 8'b0000_0111);
        chk("lit_md1_busy", bv, 8'b0000_0110);
        chk("lit_md1_done", dv, 8'b0000_1000);
        @(negedge clk); chk("lit_md1_idle", {hz.StallE, hz.MdBusy, hz.MdDone}, 3'b000);
        nextCyc();

        sv = 0; bv = 0; dv = 0;
        hz.MdStartE = 1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            sv[i] = hz.StallE; bv[i] = hz.MdBusy; dv[i] = hz.MdDone;
            nextCyc();
        end
        hz.MdStartE = 0;
        chk("lit_b2b_stallE", sv, 8'b0111_0111);
        chk("lit_b2b_busy", bv, 8'b0110_0110);
        chk("lit_b2b_done", dv, 8'b1000_1000);
        nextCyc();

        hz.MdStartE = 1;
        @(negedge clk); chk("lit_ov_idlehold", {hz.StallE, hz.MdBusy}, 2'b10);
        nextCyc();
        hz.MemToRegE = 1; hz.RegWriteE = 1; hz.WriteRegE = 8; hz.RtD = 8;
        @(negedge clk);
        chk("lit_ov_stall", {hz.StallF, hz.StallD, hz.StallE, hz.FlushE}, 4'b1110);
        chk("lit_ov_busy", hz.MdBusy, 1'b1);
        nextCyc();
        chk("lit_rb_busy", hz.MdBusy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("lit_rb_out", {hz.ForwardAE, hz.ForwardBE, hz.StallF, hz.StallD, hz.StallE,
                           hz.FlushE, hz.MdBusy, hz.MdDone}, 0);
        hz.MdStartE = 0;
        clearIn();
        nextCyc();
        rst_n = 1'b1;
        @(negedge clk); chk("lit_rel_idle", {hz.MdBusy, hz.StallE, hz.MdDone}, 3'b000);
        nextCyc();
        nextCyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
